// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between four byte-stream
// requesters, granting ownership per packet in round-robin order.
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT_CYCLES consecutive stalled cycles in SEND (o_TimeoutFlag pulses).
// Without the macro the grant is held indefinitely and o_TimeoutFlag is 0.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned N_REQ          = 4
) (
    input  logic               i_SysClock,
    input  logic               i_ResetN,
    input  logic [N_REQ-1:0]   i_ReqValid,
    input  logic [8*N_REQ-1:0] i_ReqByte,
    input  logic [N_REQ-1:0]   i_ReqLast,
    output logic [N_REQ-1:0]   o_ReqReady,
    output logic [N_REQ-1:0]   o_Grant,
    output logic               o_TxStart,
    output logic [7:0]         o_TxByte,
    input  logic               i_TxBusy,
    output logic               o_TimeoutFlag
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arbState_t;

    // The round-robin index arithmetic relies on a power-of-two requester count.
    if (N_REQ != 4 || TIMEOUT_CYCLES == 0) begin : g_badParams
        $error("uart_tx_arbiter: N_REQ must be 4 and TIMEOUT_CYCLES must be nonzero");
    end

    arbState_t        state;
    logic [IDX_W-1:0] lastOwner;   // owner of the most recently finished or revoked packet
    logic [IDX_W-1:0] grantIdx;    // binary form of o_Grant while a grant is held
    logic             lastFlag;    // i_ReqLast captured with the byte in flight
    logic [IDX_W-1:0] pickIdx;
    logic             pickValid;
    logic             accept;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stallCnt;
`endif

    // Round-robin search: first valid requester starting after lastOwner, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves it unassigned and no latch is inferred.
        pickValid = 1'b0;
        pickIdx   = lastOwner;
        for (int i = 1; i <= N_REQ; i++) begin
            logic [IDX_W-1:0] cand;
            cand = lastOwner + IDX_W'(i);
            if (!pickValid && i_ReqValid[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    // Ready is combinational so the owner sees its accept in the same cycle it offers a byte.
    assign o_ReqReady = {N_REQ{(state == SEND) && !i_TxBusy}} & o_Grant & i_ReqValid;
    assign accept     = |o_ReqReady;

    // Arbitration FSM with registered grant, start pulse, byte and timeout flag.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state     <= IDLE;
            o_Grant   <= '0;
            grantIdx  <= '0;
            lastOwner <= IDX_W'(N_REQ - 1);
            lastFlag  <= 1'b0;
            o_TxStart <= 1'b0;
            o_TxByte  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            stallCnt      <= '0;
            o_TimeoutFlag <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            o_TxStart <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            o_TimeoutFlag <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        o_Grant  <= N_REQ'(1) << pickIdx;
                        grantIdx <= pickIdx;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        o_TxByte  <= i_ReqByte[{grantIdx, 3'b000} +: 8];
                        lastFlag  <= i_ReqLast[grantIdx];
                        o_TxStart <= 1'b1;
                        state     <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                        stallCnt  <= '0;
                    end else if (!i_ReqValid[grantIdx]) begin
                        if (stallCnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                            o_Grant       <= '0;
                            lastOwner     <= grantIdx;
                            o_TimeoutFlag <= 1'b1;
                            stallCnt      <= '0;
                            state         <= IDLE;
                        end else begin
                            stallCnt <= stallCnt + 1'b1;
                        end
                    end else begin
                        // Valid but transmitter busy: the owner is not stalling.
                        stallCnt <= '0;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (i_TxBusy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_TxBusy) begin
                        if (lastFlag) begin
                            o_Grant   <= '0;
                            lastOwner <= grantIdx;
                            state     <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_ARB_TIMEOUT_EN
    assign o_TimeoutFlag = 1'b0;
`endif

endmodule
